nmea_sentence_assembler: RTL

Byte-stream front end for the GPS path. Consumes received bytes from the GPS UART receiver and frames NMEA sentences. It filters for the configured sentence header, verifies the XOR checksum, and packs each valid sentence MSB-first into the 560-bit string consumed by `NMEAparser`. Emits a one-cycle `sentence_valid` strobe and holds the string stable until the next good sentence.

---
 rtl/nmea_sentence_assembler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/nmea_sentence_assembler.sv
// Frames NMEA sentences from a UART byte stream: header filter, XOR checksum check,
// and MSB-first packing of each good sentence into a wide output string.
module nmea_sentence_assembler #(
  parameter int          SYSCLK_FREQ    = 100_000_000,
  parameter int          MAX_CHARS      = 70,
  parameter logic [39:0] HEADER         = "GPGGA",
  parameter int          TIMEOUT_CYCLES = SYSCLK_FREQ / 100
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [8*MAX_CHARS-1:0] dataString,
  output logic [6:0]             char_count,
  output logic                   sentence_valid,
  output logic                   checksum_err,
  output logic                   frame_err
);

  localparam int             BW       = 8 * MAX_CHARS;
  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     DOLLAR   = 8'h24;
  localparam logic [7:0]     STAR     = 8'h2A;
  localparam logic [7:0]     CR       = 8'h0D;
  localparam logic [7:0]     LF       = 8'h0A;

  typedef enum logic [2:0] {IDLE, HDR, BODY, CK_HI, CK_LO, TERM} state_t;

  state_t        state;
  logic [BW-1:0] wbuf;
  logic [6:0]    idx;
  logic [7:0]    xor_acc;
  logic [7:0]    ck_rx;
  logic [TW-1:0] tmo;
  logic [4:0]    hex;

  // {valid, nibble}; only uppercase hex digits are accepted
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46)
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'b0;
  endfunction

  // Header character expected at buffer index i (1..5)
  function automatic logic [7:0] hdr_char(input logic [6:0] i);
    logic [39:0] sh;
    sh = HEADER >> (8 * (5 - int'(i)));
    return sh[7:0];
  endfunction

  function automatic logic overflow(input logic [6:0] i);
    return int'(i) >= MAX_CHARS;
  endfunction

  assign hex = hex_decode(rx_data);

  always_ff @(posedge sclk) begin
    if (rst) begin
      state          <= IDLE;
      wbuf           <= '0;
      idx            <= '0;
      xor_acc        <= '0;
      ck_rx          <= '0;
      tmo            <= '0;
      dataString     <= '0;
      char_count     <= '0;
      sentence_valid <= 1'b0;
      checksum_err   <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      sentence_valid <= 1'b0;
      checksum_err   <= 1'b0;
      frame_err      <= 1'b0;
      if (rx_valid) begin
        tmo <= '0;
        // '$' restarts assembly from any state, silently dropping a partial sentence
        if (rx_data == DOLLAR) begin
          wbuf    <= {DOLLAR, {(BW-8){1'b0}}};
          idx     <= 7'd1;
          xor_acc <= '0;
          state   <= HDR;
        end else begin
          case (state)
            IDLE: ;
            HDR: begin
              if (rx_data != hdr_char(idx)) begin
                state <= IDLE;
              end else begin
                wbuf[BW-1-8*int'(idx) -: 8] <= rx_data;
                xor_acc <= xor_acc ^ rx_data;
                idx     <= idx + 7'd1;
                if (idx == 7'd5) state <= BODY;
              end
            end
            BODY: begin
              if (overflow(idx)) begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end else begin
                wbuf[BW-1-8*int'(idx) -: 8] <= rx_data;
                idx <= idx + 7'd1;
                if (rx_data == STAR) state <= CK_HI;
                else                 xor_acc <= xor_acc ^ rx_data;
              end
            end
            CK_HI, CK_LO: begin
              if (overflow(idx) || !hex[4]) begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end else begin
                wbuf[BW-1-8*int'(idx) -: 8] <= rx_data;
                idx <= idx + 7'd1;
                if (state == CK_HI) begin
                  ck_rx[7:4] <= hex[3:0];
                  state      <= CK_LO;
                end else begin
                  ck_rx[3:0] <= hex[3:0];
                  state      <= TERM;
                end
              end
            end
            TERM: begin
              if (rx_data == CR || rx_data == LF) begin
                if (ck_rx == xor_acc) begin
                  dataString     <= wbuf;
                  char_count     <= idx;
                  sentence_valid <= 1'b1;
                end else begin
                  checksum_err <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
              end
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end else if (state != IDLE) begin
        // An arriving byte always beats the timeout, so this only fires on a quiet cycle
        if (tmo == TMO_LAST) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          tmo       <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end

endmodule
